// File: rtl/ppb_io_bridge.sv
// Front-panel bridge: synchronises/debounces PPB panel inputs, generates step pulses,
// sequences programming writes and registers the CPU status vector onto the panel.
module ppb_io_bridge #(
   parameter int unsigned IN_W        = 60,
   parameter int unsigned OUT_W       = 120,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IN_W-1:0]   device_inputs,
   input  logic [OUT_W-1:0]  cpu_status,
   output logic [OUT_W-1:0]  device_outputs,
   output logic              clk_auto_en,
   output logic              clk_step,
   output logic              reset_req,
   output logic              programming_en,
   output logic              prog_we,
   output logic [ADDR_W-1:0] ProgrammingAddress,
   output logic [DATA_W-1:0] ProgrammingData
);

   localparam int unsigned P    = 3 + ADDR_W + DATA_W;
   localparam int unsigned USED = P + 3;
   localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_RELEASE} state_t;

   logic [SYNC_STAGES-1:0][USED-1:0] sync_q;
   logic [USED-1:0]   sync_v;
   logic [5:0]        ctrl_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;
   logic [5:0]        deb_q, deb_d;
   logic [5:0][CW-1:0] cnt_q, cnt_d;
   logic              step_prev_q, pw_prev_q, clk_step_q;
   logic              pw_rise;
   state_t            state_q;
   logic              we_q, active_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [OUT_W-1:0]  dout_q;

   if (IN_W > USED) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^device_inputs[IN_W-1:USED];
   end

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], device_inputs[USED-1:0]};
   end

   // Control order: [0] auto_en, [1] step, [2] reset_req, [3] prog_en, [4] prog_write, [5] freeze
   assign sync_v = sync_q[SYNC_STAGES-1];
   assign ctrl_s = {sync_v[P+2:P], sync_v[2:0]};
   assign addr_s = sync_v[3 +: ADDR_W];
   assign data_s = sync_v[3+ADDR_W +: DATA_W];

   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int unsigned b = 0; b < 6; b++) begin
         if (ctrl_s[b] != deb_q[b]) begin
            if (cnt_q[b] == DEB_LAST) deb_d[b] = ~deb_q[b];
            else                      cnt_d[b] = cnt_q[b] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_q       <= '0;
         cnt_q       <= '0;
         step_prev_q <= 1'b0;
         pw_prev_q   <= 1'b0;
         clk_step_q  <= 1'b0;
      end else begin
         deb_q       <= deb_d;
         cnt_q       <= cnt_d;
         step_prev_q <= deb_q[1];
         pw_prev_q   <= deb_q[4];
         clk_step_q  <= deb_q[1] & ~step_prev_q;
      end
   end

   assign pw_rise = deb_q[4] & ~pw_prev_q;

   // WRITE always lasts one cycle; prog_en only decides where it goes afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         active_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (deb_q[3]) begin
                  state_q  <= S_ARMED;
                  active_q <= 1'b1;
               end
            end
            S_ARMED: begin
               if (!deb_q[3]) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end else if (pw_rise) begin
                  state_q <= S_WRITE;
                  we_q    <= 1'b1;
                  addr_q  <= addr_s;
                  data_q  <= data_s;
               end
            end
            S_WRITE: begin
               if (deb_q[3]) begin
                  state_q <= S_RELEASE;
               end else begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end
            end
            S_RELEASE: begin
               if (!deb_q[3]) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end else if (!deb_q[4]) begin
                  state_q <= S_ARMED;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)          dout_q <= '0;
      else if (!deb_q[5]) dout_q <= cpu_status;
   end

   assign device_outputs     = dout_q;
   assign clk_auto_en        = deb_q[0];
   assign clk_step           = clk_step_q;
   assign reset_req          = deb_q[2];
   assign programming_en     = active_q;
   assign prog_we            = we_q;
   assign ProgrammingAddress = addr_q;
   assign ProgrammingData    = data_q;

endmodule

// File: tb/tb_ppb_io_bridge.sv
// Self-checking bench for ppb_io_bridge: directed panel scenarios plus randomized
// traffic, compared against a cycle-level behavioural model of the panel rules.
module tb_ppb_io_bridge;

   localparam int IN_W = 60, OUT_W = 120, AW = 8, DW = 8, SS = 2, DC = 4;
   localparam int P    = 3 + AW + DW;
   localparam int USED = P + 3;
   localparam int ALLW = OUT_W + 5 + AW + DW;
   localparam int M_IDLE = 0, M_ARMED = 1, M_WRITE = 2, M_RELEASE = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [IN_W-1:0]  din;
   logic [OUT_W-1:0] stat;
   logic [OUT_W-1:0] device_outputs;
   logic             clk_auto_en, clk_step, reset_req, programming_en, prog_we;
   logic [AW-1:0]    ProgrammingAddress;
   logic [DW-1:0]    ProgrammingData;
   logic [ALLW-1:0]  dut_all;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ppb_io_bridge #(
      .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(AW), .DATA_W(DW),
      .SYNC_STAGES(SS), .DEB_CYCLES(DC)
   ) dut (
      .clk(clk), .reset(reset), .device_inputs(din), .cpu_status(stat),
      .device_outputs(device_outputs), .clk_auto_en(clk_auto_en), .clk_step(clk_step),
      .reset_req(reset_req), .programming_en(programming_en), .prog_we(prog_we),
      .ProgrammingAddress(ProgrammingAddress), .ProgrammingData(ProgrammingData)
   );

   assign dut_all = {device_outputs, clk_auto_en, clk_step, reset_req, programming_en,
                     prog_we, ProgrammingAddress, ProgrammingData};

   // Behavioural model: delayed input history, per-control mismatch run length,
   // programming session mode and a status holding register.
   logic [USED-1:0]  m_pipe [SS];
   bit               m_deb [6];
   int               m_run [6];
   bit               m_step, m_step_prev, m_pw_prev, m_we;
   int               m_st;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_data;
   logic [OUT_W-1:0] m_dout;

   task automatic model_clear();
      for (int i = 0; i < SS; i++) m_pipe[i] = '0;
      for (int b = 0; b < 6; b++) begin m_deb[b] = 0; m_run[b] = 0; end
      m_step = 0; m_step_prev = 0; m_pw_prev = 0; m_we = 0; m_st = M_IDLE;
      m_addr = '0; m_data = '0; m_dout = '0;
   endtask

   task automatic model_edge();
      logic [USED-1:0] s;
      bit c [6];
      bit od [6];
      bit rise;
      if (reset) begin
         model_clear();
         return;
      end
      s = m_pipe[SS-1];
      c[0] = s[0]; c[1] = s[1]; c[2] = s[2]; c[3] = s[P]; c[4] = s[P+1]; c[5] = s[P+2];
      od = m_deb;
      m_step = od[1] && !m_step_prev;
      m_step_prev = od[1];
      rise = od[4] && !m_pw_prev;
      m_pw_prev = od[4];
      m_we = 0;
      case (m_st)
         M_IDLE:    if (od[3]) m_st = M_ARMED;
         M_ARMED:   if (!od[3]) m_st = M_IDLE;
                    else if (rise) begin
                       m_st = M_WRITE; m_we = 1;
                       m_addr = s[3 +: AW]; m_data = s[3+AW +: DW];
                    end
         M_WRITE:   m_st = od[3] ? M_RELEASE : M_IDLE;
         default:   if (!od[3]) m_st = M_IDLE; else if (!od[4]) m_st = M_ARMED;
      endcase
      if (!od[5]) m_dout = stat;
      for (int b = 0; b < 6; b++) begin
         if (c[b] != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == DC) begin m_deb[b] = !m_deb[b]; m_run[b] = 0; end
         end else m_run[b] = 0;
      end
      for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = din[USED-1:0];
   endtask

   function automatic logic [ALLW-1:0] exp_all();
      return {m_dout, m_deb[0], m_step, m_deb[2], (m_st != M_IDLE), m_we, m_addr, m_data};
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OUT_W-1:0] rnd_status();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[OUT_W-1:0];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      din = {$urandom, $urandom};
      stat = rnd_status();
      for (int k = 0; k < 3; k++) tick();
      total++;
      if (dut_all !== '0) begin
         bad++; $display("FAIL reset_zero got=%h exp=0", dut_all);
      end
      reset = 1'b0;
      din = '0;
      stat = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (dut_all !== exp_all()) begin
            bad++; $display("FAIL reset_model got=%h exp=%h", dut_all, exp_all());
         end
      end
   endtask

   task automatic test_step();
      int pulses = 0;
      din[1] = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      din[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (clk_step) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL step_glitch got=%0d pulses exp=0", pulses);
      end
      din[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         total++;
         if (clk_step !== (k == SS + DC + 1)) begin
            bad++; $display("FAIL step_timing cycle=%0d got=%b exp=%b", k, clk_step, k == SS + DC + 1);
         end
         total++;
         if (dut_all !== exp_all()) begin
            bad++; $display("FAIL step_model got=%h exp=%h", dut_all, exp_all());
         end
      end
      din[1] = 1'b0;
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic test_prog_write();
      int pulses = 0;
      din[P] = 1'b1;
      din[3 +: AW] = 8'h3C;
      din[3+AW +: DW] = 8'hA5;
      for (int k = 0; k < 10; k++) tick();
      total++;
      if (programming_en !== 1'b1) begin
         bad++; $display("FAIL prog_armed got=%b exp=1", programming_en);
      end
      din[P+1] = 1'b1;
      for (int k = 0; k < 22; k++) begin
         if (k == 8) din[P+1] = 1'b0;
         tick();
         if (prog_we) pulses++;
         total++;
         if (dut_all !== exp_all()) begin
            bad++; $display("FAIL prog_model got=%h exp=%h", dut_all, exp_all());
         end
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("FAIL prog_we_count got=%0d exp=1", pulses);
      end
      total++;
      if ({ProgrammingAddress, ProgrammingData} !== 16'h3CA5) begin
         bad++; $display("FAIL prog_latch got=%h exp=3ca5", {ProgrammingAddress, ProgrammingData});
      end
      total++;
      if ({programming_en, prog_we} !== 2'b10) begin
         bad++; $display("FAIL prog_rearmed got=%b exp=10", {programming_en, prog_we});
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] seen [$];
      for (int w = 0; w < 2; w++) begin
         din[3 +: AW] = AW'(8'h10 + w);
         din[3+AW +: DW] = DW'($urandom);
         din[P+1] = 1'b1;
         for (int k = 0; k < 20; k++) begin
            if (k == 8) din[P+1] = 1'b0;
            tick();
            if (prog_we) seen.push_back(ProgrammingAddress);
         end
      end
      total++;
      if (seen.size() !== 2) begin
         bad++; $display("FAIL b2b_count got=%0d exp=2", seen.size());
      end else begin
         total++;
         if (seen[0] !== 8'h10 || seen[1] !== 8'h11) begin
            bad++; $display("FAIL b2b_addr got=%h,%h exp=10,11", seen[0], seen[1]);
         end
      end
   endtask

   task automatic test_write_before_enable();
      int pulses = 0;
      din = '0;
      for (int k = 0; k < 12; k++) tick();
      total++;
      if (programming_en !== 1'b0) begin
         bad++; $display("FAIL wbe_idle got=%b exp=0", programming_en);
      end
      din[P+1] = 1'b1;
      for (int k = 0; k < 12; k++) begin tick(); if (prog_we) pulses++; end
      din[P] = 1'b1;
      for (int k = 0; k < 12; k++) begin tick(); if (prog_we) pulses++; end
      total++;
      if (pulses !== 0 || programming_en !== 1'b1) begin
         bad++; $display("FAIL wbe_held got=%0d pulses en=%b exp=0 pulses en=1", pulses, programming_en);
      end
      din[P+1] = 1'b0;
      for (int k = 0; k < 12; k++) begin tick(); if (prog_we) pulses++; end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL wbe_release got=%0d exp=0", pulses);
      end
      din[P+1] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 8) din[P+1] = 1'b0;
         tick();
         if (prog_we) pulses++;
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("FAIL wbe_repress got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_freeze();
      logic [OUT_W-1:0] v;
      stat = {15{8'h55}};
      din[P+2] = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      stat = {15{8'hAA}};
      for (int k = 0; k < 6; k++) tick();
      total++;
      if (device_outputs !== {15{8'h55}}) begin
         bad++; $display("FAIL freeze_hold got=%h exp=%h", device_outputs, {15{8'h55}});
      end
      din[P+2] = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      total++;
      if (device_outputs !== {15{8'hAA}}) begin
         bad++; $display("FAIL freeze_release got=%h exp=%h", device_outputs, {15{8'hAA}});
      end
      for (int k = 0; k < 4; k++) begin
         v = rnd_status();
         stat = v;
         tick();
         total++;
         if (device_outputs !== v) begin
            bad++; $display("FAIL follow_lat1 got=%h exp=%h", device_outputs, v);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      bit hit = 0;
      din = '0;
      din[P] = 1'b1;
      din[3 +: AW] = AW'($urandom);
      din[3+AW +: DW] = DW'($urandom);
      for (int k = 0; k < 10; k++) tick();
      din[P+1] = 1'b1;
      for (int k = 0; k < 20 && !hit; k++) begin
         tick();
         if (prog_we) hit = 1;
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL rst_write_timeout got=no prog_we exp=prog_we within 20 cycles");
      end
      reset = 1'b1;
      tick();
      total++;
      if (dut_all !== '0) begin
         bad++; $display("FAIL rst_mid_write got=%h exp=0", dut_all);
      end
      reset = 1'b0;
      din = '0;
      for (int k = 0; k < 12; k++) begin
         tick();
         total++;
         if (dut_all !== exp_all()) begin
            bad++; $display("FAIL rst_recover got=%h exp=%h", dut_all, exp_all());
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] ctrl = '0;
      int errs = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 5) == 0) ctrl[b] = ~ctrl[b];
         din = {$urandom, $urandom};
         din[2:0] = ctrl[2:0];
         din[P+2:P] = ctrl[5:3];
         stat = rnd_status();
         reset = ($urandom_range(0, 299) == 0);
         tick();
         total++;
         if (dut_all !== exp_all()) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL random_model cycle=%0d got=%h exp=%h", k, dut_all, exp_all());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      din = '0;
      stat = '0;
      model_clear();
      test_reset();
      test_step();
      test_prog_write();
      test_back_to_back();
      test_write_before_enable();
      test_freeze();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
